instr_fetch: RTL

//  Fetch stage feeding decode: owns the program counter and drives the 6-bit address of the

---
 rtl/instr_fetch_if.sv | 30 +++
 rtl/instr_fetch.sv | 107 ++++++++++
 2 files changed

// File: rtl/instr_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_if
// Brief    : ROM, redirect and decode handshake bundle for the fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
interface instr_fetch_if #(
    parameter int ADDR_W  = 6,
    parameter int INSTR_W = 26
);
    logic [ADDR_W-1:0]  rom_addr;
    logic [INSTR_W-1:0] rom_data;
    logic               redirect_vld;
    logic [ADDR_W-1:0]  redirect_pc;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_pc;
    logic               instr_vld;
    logic               instr_rdy;

    // master = fetch stage, slave = ROM/branch unit/decode side
    modport master (
        output rom_addr, instr, instr_pc, instr_vld,
        input  rom_data, redirect_vld, redirect_pc, instr_rdy
    );
    modport slave (
        input  rom_addr, instr, instr_pc, instr_vld,
        output rom_data, redirect_vld, redirect_pc, instr_rdy
    );
endinterface
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Brief    : PC owner and one-entry output register feeding decode.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch #(
    parameter int ADDR_W   = 6,
    parameter int INSTR_W  = 26,
    parameter int RESET_PC = 0,
    parameter int LAST_PC  = 63,
    parameter int WRAP     = 0
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic       start,
    instr_fetch_if.master   bus,
    output logic            done,
    output logic [7:0]      fetch_cnt
);
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [ADDR_W-1:0] c_RESET_PC = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] c_LAST_PC  = ADDR_W'(LAST_PC);

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [ADDR_W-1:0]  r_pc;
    logic [INSTR_W-1:0] r_instr;
    logic [ADDR_W-1:0]  r_instr_pc;
    logic               r_instr_vld;
    logic [7:0]         r_fetch_cnt;

    logic               w_redir;
    logic               w_hs;
    logic               w_cap;
    logic               w_at_last;
    logic [ADDR_W-1:0]  w_redir_pc;
    logic [ADDR_W-1:0]  w_pc_inc;

    assign w_redir    = bus.redirect_vld && (r_state != c_IDLE);
    assign w_hs       = r_instr_vld && bus.instr_rdy;
    assign w_cap      = (r_state == c_RUN) && !bus.redirect_vld && (!r_instr_vld || bus.instr_rdy);
    assign w_at_last  = (r_pc == c_LAST_PC);
    assign w_redir_pc = (bus.redirect_pc > c_LAST_PC) ? c_LAST_PC : bus.redirect_pc;
    // Without wrap the PC parks on the last address once it has been fetched
    assign w_pc_inc   = !w_at_last ? (r_pc + ADDR_W'(1)) :
                        (WRAP != 0) ? c_RESET_PC : r_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: if (start) w_state_nxt = c_RUN;
            c_RUN:  if (w_cap && w_at_last && (WRAP == 0)) w_state_nxt = c_DONE;
            c_DONE: if (bus.redirect_vld) w_state_nxt = c_RUN;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        done         = (r_state == c_DONE) && !r_instr_vld;
        bus.rom_addr = r_pc;
        bus.instr    = r_instr;
        bus.instr_pc = r_instr_pc;
        bus.instr_vld = r_instr_vld;
        fetch_cnt    = r_fetch_cnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc        <= c_RESET_PC;
            r_instr     <= '0;
            r_instr_pc  <= '0;
            r_instr_vld <= 1'b0;
        end else if (w_redir) begin
            r_pc        <= w_redir_pc;
            r_instr_vld <= 1'b0;
        end else if (w_cap) begin
            r_instr     <= bus.rom_data;
            r_instr_pc  <= r_pc;
            r_instr_vld <= 1'b1;
            r_pc        <= w_pc_inc;
        end else if (w_hs) begin
            r_instr_vld <= 1'b0;
        end
    end

    // Handshakes count even when a redirect squashes the register that cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_cnt <= 8'd0;
        end else if (w_hs && (r_fetch_cnt != 8'hFF)) begin
            r_fetch_cnt <= r_fetch_cnt + 8'd1;
        end
    end
endmodule
`default_nettype wire
